// File: rtl/ifmap_stream_feeder.sv
// ifmap_stream_feeder
//   Reads ifmap elements from a synchronous-read SRAM one row at a time and
//   writes them into the PE input-feature-map buffer as tagged words
//   {start_of_row, end_of_row, data}. It stalls cleanly on IF_full.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   rst        : asynchronous, active-low reset
//   start      : one-cycle launch pulse, ignored while busy
//   base_addr  : SRAM address of the first element (sampled on start)
//   row_len    : elements per row (sampled on start)
//   row_cnt    : number of rows (sampled on start)
//   row_pitch  : address distance between row starts (sampled on start)
//   mem_ren    : SRAM read enable
//   mem_addr   : SRAM read address
//   mem_rdata  : SRAM read data, valid the cycle after mem_ren
//   IF_full    : IF buffer full
//   IF_wen     : IF buffer write strobe
//   IF_din     : IF buffer write word {start_of_row, end_of_row, data}
//   busy       : transfer in progress
//   done       : one-cycle completion pulse
module ifmap_stream_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [LEN_WIDTH-1:0]  row_cnt,
  input  logic [ADDR_WIDTH-1:0] row_pitch,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  IF_full,
  output logic                  IF_wen,
  output logic [DATA_WIDTH+1:0] IF_din,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    row_len_q, row_len_d;
  logic [LEN_WIDTH-1:0]    row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0]   row_pitch_q, row_pitch_d;
  logic [LEN_WIDTH-1:0]    elem_idx_q, elem_idx_d;
  logic [LEN_WIDTH-1:0]    row_idx_q, row_idx_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]   row_start_q, row_start_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              tag_q, tag_d;
  logic                    zero_done_q, zero_done_d;

  logic [DATA_WIDTH+1:0]   q_mem_q [2];
  logic [DATA_WIDTH+1:0]   q_mem_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;

  logic                    start_ok;
  logic                    start_zero;
  logic                    last_elem;
  logic                    last_row;
  logic                    pop;
  logic                    push;
  logic [1:0]              occ_after_pop;
  logic                    issue;
  logic                    drained;

  // Shared decode used by the FSM and the datapath.
  // The read-issue test counts the pop happening this cycle so that a
  // steady stream with IF_full low sustains one element per cycle, while a
  // stalled write side still caps queue plus in-flight reads at two.
  always_comb begin
    start_ok      = (state_q == IDLE) && start && (row_len != '0) && (row_cnt != '0);
    start_zero    = (state_q == IDLE) && start && ((row_len == '0) || (row_cnt == '0));
    last_elem     = (elem_idx_q == (row_len_q - LEN_ONE));
    last_row      = (row_idx_q == (row_cnt_q - LEN_ONE));
    pop           = (count_q != 2'd0) && !IF_full;
    push          = inflight_q;
    occ_after_pop = 2'(count_q + {1'b0, inflight_q} - {1'b0, pop});
    issue         = (state_q == RUN) && (occ_after_pop < 2'd2);
    drained       = !inflight_q && (count_q == 2'd0);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: RUN until the final read is issued, FLUSH until the
  // pipeline and queue have drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (issue && last_elem && last_row) state_d = FLUSH;
      FLUSH:   if (drained) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. done covers both the drained FLUSH cycle and the
  // registered pulse for a zero-sized request.
  always_comb begin
    busy     = (state_q != IDLE);
    mem_ren  = issue;
    mem_addr = issue ? rd_addr_q : '0;
    IF_wen   = pop;
    IF_din   = q_mem_q[rd_ptr_q];
    done     = ((state_q == FLUSH) && drained) || zero_done_q;
  end

  // Read-side datapath: parameter latch, element/row walk and tag capture.
  // Tags are decided when the read is issued and travel with it.
  always_comb begin
    row_len_d   = row_len_q;
    row_cnt_d   = row_cnt_q;
    row_pitch_d = row_pitch_q;
    elem_idx_d  = elem_idx_q;
    row_idx_d   = row_idx_q;
    rd_addr_d   = rd_addr_q;
    row_start_d = row_start_q;
    tag_d       = tag_q;
    inflight_d  = issue;
    zero_done_d = start_zero;
    if (start_ok) begin
      row_len_d   = row_len;
      row_cnt_d   = row_cnt;
      row_pitch_d = row_pitch;
      elem_idx_d  = '0;
      row_idx_d   = '0;
      rd_addr_d   = base_addr;
      row_start_d = base_addr;
    end else if (issue) begin
      tag_d = {elem_idx_q == '0, last_elem};
      if (last_elem) begin
        elem_idx_d  = '0;
        row_idx_d   = row_idx_q + LEN_ONE;
        rd_addr_d   = row_start_q + row_pitch_q;
        row_start_d = row_start_q + row_pitch_q;
      end else begin
        elem_idx_d = elem_idx_q + LEN_ONE;
        rd_addr_d  = rd_addr_q + ADDR_ONE;
      end
    end
  end

  // Two-entry queue: returning SRAM data is pushed with its tag the cycle
  // after the read, the head is popped on every IF write.
  always_comb begin
    q_mem_d[0] = q_mem_q[0];
    q_mem_d[1] = q_mem_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      q_mem_d[wr_ptr_q] = {tag_q, mem_rdata};
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = 2'(count_q + {1'b0, push} - {1'b0, pop});
  end

  // Datapath and queue registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_len_q   <= '0;
      row_cnt_q   <= '0;
      row_pitch_q <= '0;
      elem_idx_q  <= '0;
      row_idx_q   <= '0;
      rd_addr_q   <= '0;
      row_start_q <= '0;
      inflight_q  <= 1'b0;
      tag_q       <= 2'b00;
      zero_done_q <= 1'b0;
      q_mem_q[0]  <= '0;
      q_mem_q[1]  <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      row_len_q   <= row_len_d;
      row_cnt_q   <= row_cnt_d;
      row_pitch_q <= row_pitch_d;
      elem_idx_q  <= elem_idx_d;
      row_idx_q   <= row_idx_d;
      rd_addr_q   <= rd_addr_d;
      row_start_q <= row_start_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      zero_done_q <= zero_done_d;
      q_mem_q[0]  <= q_mem_d[0];
      q_mem_q[1]  <= q_mem_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_ifmap_stream_feeder.sv
// tb_ifmap_stream_feeder
//   Directed bench for ifmap_stream_feeder. Stimulus pushes the expected
//   read addresses and tagged IF words into queues; an independent monitor
//   on the falling edge pops and compares whenever the DUT reads or writes.
module tb_ifmap_stream_feeder;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] row_len;
  logic [LW-1:0] row_cnt;
  logic [AW-1:0] row_pitch;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          IF_full;
  logic          IF_wen;
  logic [DW+1:0] IF_din;
  logic          busy;
  logic          done;

  ifmap_stream_feeder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .row_len  (row_len),
    .row_cnt  (row_cnt),
    .row_pitch(row_pitch),
    .mem_ren  (mem_ren),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .IF_full  (IF_full),
    .IF_wen   (IF_wen),
    .IF_din   (IF_din),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read SRAM: address pattern 7*a+3, first five words overridden
  logic [DW-1:0] sram [1024];
  initial begin
    for (int a = 0; a < 1024; a++) sram[a] = 16'(a * 7 + 3);
    sram[0] = 16'(161);
    sram[1] = 16'(190);
    sram[2] = 16'(-161);
    sram[3] = 16'(-81);
    sram[4] = 16'(50);
  end
  always @(posedge clk) if (mem_ren) mem_rdata <= sram[mem_addr];

  logic [AW-1:0] exp_addr [$];
  logic [DW+1:0] exp_din  [$];
  int tests_run    = 0;
  int tests_failed = 0;
  int start_edge   = 0;
  bit first_pending = 1'b0;
  int rd_issued = 0;
  int wr_done   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic flagFail(input string name, input logic [31:0] actual);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, actual);
  endtask

  task automatic expectRead(input logic [AW-1:0] addr, input logic [1:0] tag,
                            input logic [DW-1:0] data);
    exp_addr.push_back(addr);
    exp_din.push_back({tag, data});
  endtask

  // Monitor: every read and write is matched against the scoreboard
  always @(negedge clk) begin
    if (mem_ren) begin
      rd_issued++;
      if (exp_addr.size() == 0) flagFail("unexpected_read", 32'(mem_addr));
      else checkOutput("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
    end
    if (IF_wen) begin
      wr_done++;
      checkOutput("wen_while_full", 32'(IF_full), 0);
      if (exp_din.size() == 0) flagFail("unexpected_write", 32'(IF_din));
      else checkOutput("if_din", 32'(IF_din), 32'(exp_din.pop_front()));
      if (first_pending) begin
        checkOutput("first_wen_latency", 32'(cyc - start_edge), 2);
        first_pending = 1'b0;
      end
    end
    if (mem_ren) checkOutput("outstanding_le_2", 32'((rd_issued - wr_done) <= 2), 1);
  end

  // Issue a start pulse; start_edge is the cycle index of the sampling edge
  task automatic applyStimulus(input logic [AW-1:0] b, input logic [LW-1:0] l,
                               input logic [LW-1:0] c, input logic [AW-1:0] p);
    @(negedge clk);
    base_addr = b;
    row_len   = l;
    row_cnt   = c;
    row_pitch = p;
    start     = 1'b1;
    rd_issued = 0;
    wr_done   = 0;
    first_pending = (l != 0) && (c != 0);
    @(posedge clk);
    #1;
    start_edge = cyc;
    start = 1'b0;
  endtask

  task automatic runTransfer(input string name, input logic [AW-1:0] b,
                             input logic [LW-1:0] l, input logic [LW-1:0] c,
                             input logic [AW-1:0] p, input int full_lo,
                             input int full_hi, input int restart_rel,
                             input int exp_done_rel);
    int rel;
    bit seen;
    applyStimulus(b, l, c, p);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      rel = cyc - start_edge;
      IF_full = (rel >= full_lo) && (rel <= full_hi);
      start = (rel == restart_rel);
      if (start) begin
        base_addr = 10'd500;
        row_len   = 8'd2;
        row_cnt   = 8'd2;
        row_pitch = 10'd3;
      end
      if (rel == 0) checkOutput({name, "_busy"}, 32'(busy), 32'((l != 0) && (c != 0)));
      if (done) begin
        seen = 1'b1;
        checkOutput({name, "_done_cycle"}, 32'(rel), 32'(exp_done_rel));
      end else begin
        @(posedge clk);
        #1;
      end
    end
    start   = 1'b0;
    IF_full = 1'b0;
    if (!seen) flagFail({name, "_done_timeout"}, 32'(cyc - start_edge));
    @(posedge clk);
    #1;
    checkOutput({name, "_done_one_cycle"}, 32'(done), 0);
    checkOutput({name, "_idle_after"}, 32'(busy), 0);
    checkOutput({name, "_reads_left"}, 32'(exp_addr.size()), 0);
    checkOutput({name, "_writes_left"}, 32'(exp_din.size()), 0);
    exp_addr.delete();
    exp_din.delete();
    first_pending = 1'b0;
  endtask

  task automatic expectBasicRow();
    expectRead(10'd0, 2'b10, 16'(161));
    expectRead(10'd1, 2'b00, 16'(190));
    expectRead(10'd2, 2'b00, 16'(-161));
    expectRead(10'd3, 2'b00, 16'(-81));
    expectRead(10'd4, 2'b01, 16'(50));
  endtask

  initial begin
    bit reached;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    row_len = '0;
    row_cnt = '0;
    row_pitch = '0;
    IF_full = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_mem_ren", 32'(mem_ren), 0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 0);
    checkOutput("reset_if_wen", 32'(IF_wen), 0);
    checkOutput("reset_if_din", 32'(IF_din), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    expectBasicRow();
    runTransfer("basic", 10'd0, 8'd5, 8'd1, 10'd0, 1, 0, -1, 7);

    expectRead(10'd8,  2'b10, 16'(59));
    expectRead(10'd9,  2'b00, 16'(66));
    expectRead(10'd10, 2'b01, 16'(73));
    expectRead(10'd24, 2'b10, 16'(171));
    expectRead(10'd25, 2'b00, 16'(178));
    expectRead(10'd26, 2'b01, 16'(185));
    runTransfer("pitch", 10'd8, 8'd3, 8'd2, 10'd16, 1, 0, -1, 8);

    expectBasicRow();
    runTransfer("backpressure", 10'd0, 8'd5, 8'd1, 10'd0, 3, 8, -1, 13);

    expectRead(10'd100, 2'b11, 16'(703));
    expectRead(10'd101, 2'b11, 16'(710));
    expectRead(10'd102, 2'b11, 16'(717));
    runTransfer("len1", 10'd100, 8'd1, 8'd3, 10'd1, 1, 0, -1, 5);

    runTransfer("len0", 10'd0, 8'd0, 8'd3, 10'd1, 1, 0, -1, 0);
    runTransfer("cnt0", 10'd0, 8'd4, 8'd0, 10'd1, 1, 0, -1, 0);

    expectBasicRow();
    runTransfer("restart", 10'd0, 8'd5, 8'd1, 10'd0, 1, 0, 3, 7);

    expectRead(10'd1022, 2'b10, 16'(7157));
    expectRead(10'd1023, 2'b00, 16'(7164));
    expectRead(10'd0,    2'b00, 16'(161));
    expectRead(10'd1,    2'b01, 16'(190));
    runTransfer("wrap", 10'd1022, 8'd4, 8'd1, 10'd0, 1, 0, -1, 6);

    // Reset asserted while the third word is being written
    expectBasicRow();
    applyStimulus(10'd0, 8'd5, 8'd1, 10'd0);
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      if (cyc - start_edge == 4) reached = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!reached) flagFail("reset_test_sync", 32'(cyc - start_edge));
    checkOutput("wen_before_reset", 32'(IF_wen), 1);
    if (exp_din.size() == 0) flagFail("din_before_reset_missing", 32'(IF_din));
    else checkOutput("din_before_reset", 32'(IF_din), 32'(exp_din[0]));
    #1 rst = 1'b0;
    #1;
    checkOutput("abort_mem_ren", 32'(mem_ren), 0);
    checkOutput("abort_mem_addr", 32'(mem_addr), 0);
    checkOutput("abort_if_wen", 32'(IF_wen), 0);
    checkOutput("abort_if_din", 32'(IF_din), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    exp_addr.delete();
    exp_din.delete();
    first_pending = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    expectBasicRow();
    runTransfer("after_reset", 10'd0, 8'd5, 8'd1, 10'd0, 1, 0, -1, 7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
